// File: rtl/cordic_phase_gen_if.sv
// Sweep control, cordic 4-phase handshake and captured-result signals of cordic_phase_gen.
interface cordic_phase_gen_if;
    logic               i_start;
    logic               i_stop;
    logic [15:0]        i_step;
    logic [15:0]        i_count;
    logic               o_req;
    logic signed [19:0] o_theta;
    logic               i_ack;
    logic signed [19:0] i_sin;
    logic signed [19:0] i_cos;
    logic signed [19:0] o_sin;
    logic signed [19:0] o_cos;
    logic signed [19:0] o_theta_out;
    logic               o_valid;
    logic [15:0]        o_samples;
    logic               o_busy;
    logic               o_err;

    modport slave (
        input  i_start, i_stop, i_step, i_count, i_ack, i_sin, i_cos,
        output o_req, o_theta, o_sin, o_cos, o_theta_out, o_valid, o_samples, o_busy, o_err
    );
    modport master (
        output i_start, i_stop, i_step, i_count, i_ack, i_sin, i_cos,
        input  o_req, o_theta, o_sin, o_cos, o_theta_out, o_valid, o_samples, o_busy, o_err
    );
endinterface

// File: rtl/cordic_phase_gen.sv
// Phase sweep generator: steps an angle over [-PI, PI) and trades each angle for a
// sin/cos pair with a cordic over a 4-phase req/ack handshake, with per-edge timeout.
module cordic_phase_gen #(
    parameter logic signed [19:0] PI      = 20'sd205887,
    parameter int                 TIMEOUT = 1024
) (
    input logic               i_clk,
    input logic               i_rst,
    cordic_phase_gen_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [20:0] PI21   = 21'(PI);
    localparam logic signed [20:0] TWO_PI = PI21 + PI21;

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t             state_q, state_d;
    logic signed [19:0] theta_q, theta_d;
    logic signed [19:0] sin_q, sin_d, cos_q, cos_d, theta_out_q, theta_out_d;
    logic [15:0]        step_q, step_d, count_q, count_d, samples_q, samples_d;
    logic               valid_q, valid_d, err_q, err_d, stop_q, stop_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic signed [20:0] sum, wrapped;
    logic               tmo_hit;

    // One extra bit keeps theta + step from overflowing before the wrap test.
    always_comb begin
        sum     = 21'(theta_q) + $signed({5'b0, step_q});
        wrapped = (sum >= PI21) ? sum - TWO_PI : sum;
        tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            theta_q     <= -PI;
            sin_q       <= '0;
            cos_q       <= '0;
            theta_out_q <= '0;
            step_q      <= '0;
            count_q     <= '0;
            samples_q   <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            stop_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            theta_q     <= theta_d;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            theta_out_q <= theta_out_d;
            step_q      <= step_d;
            count_q     <= count_d;
            samples_q   <= samples_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            stop_q      <= stop_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        theta_d     = theta_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        theta_out_d = theta_out_q;
        step_d      = step_q;
        count_d     = count_q;
        samples_d   = samples_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        stop_d      = stop_q;
        tmo_d       = '0;
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    step_d    = (bus.i_step == 16'd0) ? 16'd1 : bus.i_step;
                    count_d   = bus.i_count;
                    theta_d   = -PI;
                    samples_d = '0;
                    err_d     = 1'b0;
                    stop_d    = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus.i_stop) stop_d = 1'b1;
                if (bus.i_ack) begin
                    sin_d       = bus.i_sin;
                    cos_d       = bus.i_cos;
                    theta_out_d = theta_q;
                    samples_d   = (samples_q == 16'hFFFF) ? samples_q : samples_q + 16'd1;
                    valid_d     = 1'b1;
                    state_d     = REL;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            REL: begin
                if (bus.i_stop) stop_d = 1'b1;
                if (!bus.i_ack) begin
                    // A stop arriving on the exit cycle still ends the sweep here.
                    if (stop_q || bus.i_stop || (count_q != 16'd0 && samples_q == count_q)) begin
                        state_d = IDLE;
                    end else begin
                        theta_d = 20'(wrapped);
                        state_d = REQ;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_req       = (state_q == REQ);
        bus.o_busy      = (state_q != IDLE);
        bus.o_theta     = theta_q;
        bus.o_sin       = sin_q;
        bus.o_cos       = cos_q;
        bus.o_theta_out = theta_out_q;
        bus.o_valid     = valid_q;
        bus.o_samples   = samples_q;
        bus.o_err       = err_q;
    end
endmodule

// File: doc/cordic_phase_gen.md
CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 Parameter PI, default 20'sd205887, meaning pi in signed Q3.16 (pi*2^16).
REQ-002 Parameter TIMEOUT, default 1024, meaning maximum cycles to wait on any single cordic ack edge.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_start  input  1  one-cycle pulse; begins a sweep when idle.
REQ-006 i_stop  input  1  one-cycle pulse; ends the sweep after the current handshake completes.
REQ-007 i_step  input  16  unsigned phase increment per sample, Q3.16; 0 treated as 1.
REQ-008 i_count  input  16  samples per sweep; 0 means continuous until stop.
REQ-009 o_req  output  1  request to cordic.
REQ-010 o_theta  output  20  signed angle to cordic, held stable while o_req=1.
REQ-011 i_ack  input  1  cordic acknowledge.
REQ-012 i_sin, i_cos  input  20 each  signed cordic results, valid when i_ack=1.
REQ-013 o_sin, o_cos, o_theta_out  output  20 each  registered captured result and its angle.
REQ-014 o_valid  output  1  one-cycle pulse when new result registers update.
REQ-015 o_samples  output  16  results captured in the current sweep.
REQ-016 o_busy  output  1  high in any state other than IDLE.
REQ-017 o_err  output  1  sticky timeout flag; cleared by reset or i_start.

Function
REQ-018 States IDLE, REQ, REL; the 4-phase handshake is o_req rise, i_ack rise, o_req fall, i_ack fall.
REQ-019 IDLE with i_start=1: latch i_step (0->1) and i_count, set o_theta=-PI, clear o_samples, o_err and the stop flag, go to REQ next cycle.
REQ-020 i_start outside IDLE is ignored.
REQ-021 REQ: o_req=1, o_theta unchanged.
REQ-022 REQ, on the first cycle i_ack=1:
- o_sin<=i_sin, o_cos<=i_cos, o_theta_out<=o_theta;
- o_valid=1 for the following cycle;
- o_samples+1;
- go to REL.
REQ-023 REL: o_req=0; stay until i_ack=0.
REQ-024 REL with i_ack=0:
- if the stop flag is set, or i_count!=0 and o_samples==latched count, go to IDLE;
- otherwise advance o_theta and go to REQ.
REQ-025 Advance uses a 21-bit signed sum: next = o_theta + step; if next >= PI, next -= 2*PI; result is always in [-PI, PI).
REQ-026 i_stop in REQ or REL sets the stop flag; the sweep ends at REL exit, never mid-handshake.
REQ-027 i_stop in IDLE is ignored.
REQ-028 i_stop and i_start in the same cycle in IDLE: the start is taken and the stop is ignored.
REQ-029 Timeout counter resets on every state entry. If it reaches TIMEOUT in REQ or REL: set o_err, drop o_req, go to IDLE; no capture and no o_valid.
REQ-030 o_samples saturates at 16'hFFFF in continuous mode; the sweep continues.
REQ-031 In continuous mode o_theta wraps indefinitely.
REQ-032 o_busy = (state != IDLE), combinational from the state register.

Reset
REQ-033 i_rst=1 at a clock edge forces IDLE from any state, including mid-handshake.
REQ-034 Reset values: o_req=0, o_theta=-PI, o_sin=0, o_cos=0, o_theta_out=0, o_valid=0, o_samples=0, o_busy=0, o_err=0, stop flag=0.
REQ-035 While i_rst=1, i_start is ignored.

Verification
REQ-036 Start with step=100, count=3, cordic model acking after 5 cycles -> o_theta_out sequence -205887, -205787, -205687; three o_valid pulses; then IDLE with o_samples=3.
REQ-037 Wrap: step=65535, continuous; after theta=190722 -> next theta 190722+65535-411774 = -155517; stop -> IDLE only after the REL handshake completes.
REQ-038 i_ack never asserted -> o_err=1 and o_req=0 at TIMEOUT cycles after REQ entry; state IDLE; no o_valid.
REQ-039 Reset pulse in REL with i_ack still high -> next cycle all outputs at reset values; a later start begins at -PI.
REQ-040 i_step=0, count=2 -> o_theta_out -205887, -205886.
REQ-041 i_start pulsed while busy -> no effect on theta, count or state.
